// File: rtl/fft_pkg.sv
// fft_pkg: shared types, constants and elaboration-time helpers for the
// FFT sample buffer.
//   bank_state_e : per-bank ping-pong state (EMPTY / FULL)
//   bitrev       : reverse the low 'size' bits of an index
//   twiddle      : Q1.12 cos / -sin value for index k of an n-point FFT,
//                  rounded to nearest and saturated to a w-bit signed range
package fft_pkg;

  localparam int TW_W   = 14;
  localparam int TW_ONE = 4096;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  function automatic int unsigned bitrev(input int unsigned v, input int size);
    int unsigned r;
    r = 0;
    for (int i = 0; i < size; i++) begin
      r[size-1-i] = v[i];
    end
    return r;
  endfunction

  function automatic int tw_sat(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Angle is in [0, pi) for k < n/2, so a plain Maclaurin series converges
  // well within double precision; no trig system functions are needed.
  function automatic int twiddle(input int k, input int n, input bit want_sin, input int w);
    real th;
    real term;
    real c;
    real s;
    real x;
    int  v;
    th   = 2.0 * 3.14159265358979323846 * real'(k) / real'(n);
    term = 1.0;
    c    = 0.0;
    s    = 0.0;
    for (int i = 0; i < 40; i++) begin
      case (i % 4)
        0:       c = c + term;
        1:       s = s + term;
        2:       c = c - term;
        default: s = s - term;
      endcase
      term = term * th / real'(i + 1);
    end
    x = want_sin ? (-s * real'(TW_ONE)) : (c * real'(TW_ONE));
    v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    return tw_sat(v, w);
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// fft_twiddle_rom: N/2-entry twiddle table with a registered 1-cycle read.
//   clk, rst : clock, asynchronous active-high reset (clears outputs only)
//   i_en     : load the output registers from the table
//   i_addr   : twiddle index k, 0..N/2-1
//   o_cos    : round(4096*cos(2*pi*k/N)), held when i_en is low
//   o_sin    : round(-4096*sin(2*pi*k/N)), held when i_en is low
module fft_twiddle_rom #(
  parameter int N    = 16,
  parameter int TW_W = fft_pkg::TW_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic [$clog2(N)-2:0]     i_addr,
  output logic signed [TW_W-1:0]   o_cos,
  output logic signed [TW_W-1:0]   o_sin
);
  import fft_pkg::*;

  logic signed [TW_W-1:0] w_cos_tab [N/2];
  logic signed [TW_W-1:0] w_sin_tab [N/2];

  for (genvar k = 0; k < N/2; k++) begin : g_tab
    localparam int COS_V = twiddle(k, N, 1'b0, TW_W);
    localparam int SIN_V = twiddle(k, N, 1'b1, TW_W);
    assign w_cos_tab[k] = TW_W'(COS_V);
    assign w_sin_tab[k] = TW_W'(SIN_V);
  end

  // Stage p0 -> p1: table lookup
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_cos <= '0;
      o_sin <= '0;
    end else if (i_en) begin
      o_cos <= w_cos_tab[i_addr];
      o_sin <= w_sin_tab[i_addr];
    end
  end

endmodule

// File: rtl/fft_pingpong_buf.sv
// fft_pingpong_buf: two-bank N-point complex sample buffer. Samples arrive in
// natural order and are stored at bit-reversed addresses; one bank fills while
// the other is read at random by the butterfly engine.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : input handshake; in_ready is high while the write bank is EMPTY
//   Re_i, Im_i        : signed input sample
//   frame_ready       : the read bank holds a complete frame
//   en_rd, rd_ptr     : read strobe and address within the read bank
//   tw_ptr            : twiddle index k
//   rd_done           : release the read bank back to the writer
//   Re_o, Im_o        : read data, 1-cycle latency, held when not reading
//   cos_data/sin_data : twiddle pair, aligned with Re_o/Im_o
//   en_radix          : outputs valid this cycle
module fft_pingpong_buf #(
  parameter int DATA_W = 29,
  parameter int N      = 16,
  parameter int SIZE   = 4,
  parameter int TW_W   = fft_pkg::TW_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] Re_i,
  input  logic signed [DATA_W-1:0] Im_i,
  output logic                     frame_ready,
  input  logic                     en_rd,
  input  logic [SIZE-1:0]          rd_ptr,
  input  logic [SIZE-2:0]          tw_ptr,
  input  logic                     rd_done,
  output logic signed [DATA_W-1:0] Re_o,
  output logic signed [DATA_W-1:0] Im_o,
  output logic signed [TW_W-1:0]   cos_data,
  output logic signed [TW_W-1:0]   sin_data,
  output logic                     en_radix
);
  import fft_pkg::*;

  bank_state_e              r_state [2];
  logic                     r_wr_bank;
  logic                     r_rd_bank;
  logic [SIZE-1:0]          r_wr_cnt;
  logic                     r_vld_p1;
  logic signed [DATA_W-1:0] r_mem_re [2][N];
  logic signed [DATA_W-1:0] r_mem_im [2][N];

  logic                     w_wr_acc;
  logic                     w_rd_acc;
  logic                     w_release;
  logic                     w_last;
  logic [SIZE-1:0]          w_wr_addr;

  assign in_ready    = (r_state[r_wr_bank] == BANK_EMPTY);
  assign frame_ready = (r_state[r_rd_bank] == BANK_FULL);
  assign w_wr_acc    = in_valid && in_ready;
  assign w_rd_acc    = en_rd && frame_ready;
  assign w_release   = rd_done && frame_ready;
  assign w_last      = (r_wr_cnt == SIZE'(N - 1));
  assign w_wr_addr   = SIZE'(bitrev(32'(r_wr_cnt), SIZE));

  // Bank bookkeeping. The bank being written is EMPTY and the bank being
  // released is FULL, so the two state updates never hit the same bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state[0] <= BANK_EMPTY;
      r_state[1] <= BANK_EMPTY;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_cnt   <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_last) begin
          r_state[r_wr_bank] <= BANK_FULL;
          r_wr_bank          <= ~r_wr_bank;
        end
      end
      if (w_release) begin
        r_state[r_rd_bank] <= BANK_EMPTY;
        r_rd_bank          <= ~r_rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem_re[r_wr_bank][w_wr_addr] <= Re_i;
      r_mem_im[r_wr_bank][w_wr_addr] <= Im_i;
    end
  end

  // Stage p0 -> p1: read uses the pre-release rd_bank, so a read issued with
  // rd_done still returns the bank being released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Re_o     <= '0;
      Im_o     <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_rd_acc;
      if (w_rd_acc) begin
        Re_o <= r_mem_re[r_rd_bank][rd_ptr];
        Im_o <= r_mem_im[r_rd_bank][rd_ptr];
      end
    end
  end

  assign en_radix = r_vld_p1;

  fft_twiddle_rom #(
    .N    (N),
    .TW_W (TW_W)
  ) u_tw_rom (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_rd_acc),
    .i_addr (tw_ptr),
    .o_cos  (cos_data),
    .o_sin  (sin_data)
  );

endmodule

// File: tb/tb_fft_pingpong_buf.sv
// tb_fft_pingpong_buf: directed bench for fft_pingpong_buf (N=16).
module tb_fft_pingpong_buf;
  localparam int DATA_W = 29;
  localparam int N      = 16;
  localparam int SIZE   = 4;
  localparam int TW_W   = 14;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] Re_i;
  logic signed [DATA_W-1:0] Im_i;
  logic                     frame_ready;
  logic                     en_rd;
  logic [SIZE-1:0]          rd_ptr;
  logic [SIZE-2:0]          tw_ptr;
  logic                     rd_done;
  logic signed [DATA_W-1:0] Re_o;
  logic signed [DATA_W-1:0] Im_o;
  logic signed [TW_W-1:0]   cos_data;
  logic signed [TW_W-1:0]   sin_data;
  logic                     en_radix;

  int n_checks = 0;
  int n_fail   = 0;

  fft_pingpong_buf #(
    .DATA_W (DATA_W),
    .N      (N),
    .SIZE   (SIZE),
    .TW_W   (TW_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Re_i        (Re_i),
    .Im_i        (Im_i),
    .frame_ready (frame_ready),
    .en_rd       (en_rd),
    .rd_ptr      (rd_ptr),
    .tw_ptr      (tw_ptr),
    .rd_done     (rd_done),
    .Re_o        (Re_o),
    .Im_o        (Im_o),
    .cos_data    (cos_data),
    .sin_data    (sin_data),
    .en_radix    (en_radix)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream one frame Re=base+i, Im=-(base+i) with no stalls.
  task automatic send_frame(input int base, input bit fr_before_last);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      Re_i     = DATA_W'(base + i);
      Im_i     = DATA_W'(-(base + i));
      chk("in_ready_during_frame", in_ready, 1);
      if (i == N - 1) chk("frame_ready_before_last", frame_ready, fr_before_last);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic rd(input int ptr, input int tw, input bit done);
    en_rd   = 1'b1;
    rd_ptr  = SIZE'(ptr);
    tw_ptr  = (SIZE-1)'(tw);
    rd_done = done;
    step();
    en_rd   = 1'b0;
    rd_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; Re_i = '0; Im_i = '0;
    en_rd = 1'b0; rd_ptr = '0; tw_ptr = '0; rd_done = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_Re_o", Re_o, 0);
    chk("rst_Im_o", Im_o, 0);
    chk("rst_cos", cos_data, 0);
    chk("rst_sin", sin_data, 0);
    chk("rst_en_radix", en_radix, 0);
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_in_ready", in_ready, 1);

    // en_rd / rd_done with nothing to read are ignored
    rd(3, 1, 1'b1);
    chk("idle_en_radix", en_radix, 0);
    chk("idle_Re_o", Re_o, 0);
    chk("idle_cos", cos_data, 0);
    chk("idle_frame_ready", frame_ready, 0);
    chk("idle_in_ready", in_ready, 1);

    // Frame A into bank 0
    send_frame(0, 1'b0);
    chk("frameA_ready", frame_ready, 1);
    chk("frameA_in_ready", in_ready, 1);

    rd(8, 0, 1'b0);
    chk("rd8_en_radix", en_radix, 1);
    chk("rd8_Re", Re_o, 1);
    chk("rd8_Im", Im_o, -1);
    chk("tw0_cos", cos_data, 4096);
    chk("tw0_sin", sin_data, 0);
    step();
    chk("hold_en_radix", en_radix, 0);
    chk("hold_Re", Re_o, 1);
    chk("hold_cos", cos_data, 4096);

    rd(1, 2, 1'b0);
    chk("rd1_Re", Re_o, 8);
    chk("rd1_Im", Im_o, -8);
    chk("tw2_cos", cos_data, 2896);
    chk("tw2_sin", sin_data, -2896);
    chk("rd1_en_radix", en_radix, 1);

    rd(3, 4, 1'b0);
    chk("rd3_Re", Re_o, 12);
    chk("tw4_cos", cos_data, 0);
    chk("tw4_sin", sin_data, -4096);

    // Read + release together, then a read with bank 1 not full
    en_rd = 1'b1; rd_done = 1'b1; rd_ptr = 4'd8; tw_ptr = 3'd0;
    step();
    rd_done = 1'b0; rd_ptr = 4'd1; tw_ptr = 3'd2;
    chk("rel_rd_en_radix", en_radix, 1);
    chk("rel_rd_Re", Re_o, 1);
    chk("rel_rd_Im", Im_o, -1);
    chk("rel_frame_ready", frame_ready, 0);
    step();
    en_rd = 1'b0;
    chk("empty_rd_en_radix", en_radix, 0);
    chk("empty_rd_Re_hold", Re_o, 1);
    chk("empty_rd_cos_hold", cos_data, 4096);
    chk("empty_rd_sin_hold", sin_data, 0);

    // Fill bank 1 then bank 0 without releasing
    send_frame(100, 1'b0);
    chk("bank1_ready", frame_ready, 1);
    send_frame(200, 1'b1);
    chk("both_full_in_ready", in_ready, 0);
    chk("both_full_frame_ready", frame_ready, 1);

    // 33rd sample offered while full must not land anywhere
    in_valid = 1'b1; Re_i = DATA_W'(999); Im_i = DATA_W'(-999);
    step();
    chk("stall_in_ready", in_ready, 0);
    in_valid = 1'b0;
    rd(0, 1, 1'b0);
    chk("stall_no_write_Re", Re_o, 100);
    chk("stall_no_write_Im", Im_o, -100);
    chk("tw1_cos", cos_data, 3784);
    chk("tw1_sin", sin_data, -1567);

    // Release bank 1: writer reopens, reader moves to bank 0
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    chk("after_rel_in_ready", in_ready, 1);
    chk("after_rel_frame_ready", frame_ready, 1);
    rd(8, 6, 1'b0);
    chk("bank0_rd8_Re", Re_o, 201);
    chk("bank0_rd8_Im", Im_o, -201);
    chk("tw6_cos", cos_data, -2896);
    chk("tw6_sin", sin_data, -2896);

    // Reset after 5 accepts of a partial frame
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; Re_i = DATA_W'(50 + i); Im_i = DATA_W'(-(50 + i));
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_Re_o", Re_o, 0);
    chk("midrst_Im_o", Im_o, 0);
    chk("midrst_cos", cos_data, 0);
    chk("midrst_sin", sin_data, 0);
    chk("midrst_en_radix", en_radix, 0);
    chk("midrst_frame_ready", frame_ready, 0);
    chk("midrst_in_ready", in_ready, 1);
    step();
    rst = 1'b0;

    send_frame(300, 1'b0);
    chk("fresh_frame_ready", frame_ready, 1);
    rd(8, 0, 1'b0);
    chk("fresh_rd8_Re", Re_o, 301);
    rd(4, 0, 1'b0);
    chk("fresh_rd4_Re", Re_o, 302);
    rd(15, 0, 1'b0);
    chk("fresh_rd15_Re", Re_o, 315);
    chk("fresh_rd15_Im", Im_o, -315);
    rd(0, 0, 1'b0);
    chk("fresh_rd0_Re", Re_o, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected normal end");
    $fatal(1, "timeout");
  end

endmodule
